// File: rtl/vga_display_controller.sv
// Image-select / blanking controller: debounces two buttons and applies their
// requests only at a vsync frame boundary so the picture never changes mid-frame.
module vga_display_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_IMAGES      = 3
) (
  input  logic                          i_CLK,
  input  logic                          i_RESET_N,
  input  logic                          i_CYCLE_IMAGE,
  input  logic                          i_BLANK_DISPLAY,
  input  logic                          i_VSYNC,
  output logic [$clog2(NUM_IMAGES)-1:0] o_IMAGE_SEL,
  output logic                          o_BLANK,
  output logic                          o_PENDING,
  output logic                          o_FRAME_TICK
);

  localparam int unsigned SEL_W = $clog2(NUM_IMAGES);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IMAGES - 1);

  // Button index 0 = cycle image, 1 = blank display.
  localparam int unsigned BTN_CYCLE = 0;
  localparam int unsigned BTN_BLANK = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  logic [1:0]            btn_meta;
  logic [1:0]            btn_sync;
  logic [1:0]            btn_deb;
  logic [1:0][CNT_W-1:0] btn_cnt;
  logic [1:0]            btn_rise_c;
  logic                  vs_meta;
  logic                  vs_sync;
  logic                  req_cycle;
  logic                  req_blank;
  state_t                state;

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {i_BLANK_DISPLAY, i_CYCLE_IMAGE};
      btn_sync <= btn_meta;
    end
  end

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      btn_deb <= '0;
      btn_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_LAST) begin
          btn_deb[i] <= ~btn_deb[i];
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced rising edge, asserted on the cycle the debounced level flips to 1.
  always_comb begin
    btn_rise_c = '0;
    for (int i = 0; i < 2; i++) begin
      btn_rise_c[i] = btn_sync[i] && !btn_deb[i] && (btn_cnt[i] == CNT_LAST);
    end
  end

  // Vsync synchronizer idles high so leaving reset never looks like a falling edge.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      vs_meta      <= 1'b1;
      vs_sync      <= 1'b1;
      o_FRAME_TICK <= 1'b0;
    end else begin
      vs_meta      <= i_VSYNC;
      vs_sync      <= vs_meta;
      o_FRAME_TICK <= vs_sync && !vs_meta;
    end
  end

  // Request flags and frame-aligned apply sequencer.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      state       <= IDLE;
      req_cycle   <= 1'b0;
      req_blank   <= 1'b0;
      o_IMAGE_SEL <= '0;
      o_BLANK     <= 1'b0;
      o_PENDING   <= 1'b0;
    end else begin
      req_cycle <= req_cycle | btn_rise_c[BTN_CYCLE];
      req_blank <= req_blank ^ btn_rise_c[BTN_BLANK];
      case (state)
        IDLE: begin
          if (req_cycle || req_blank) begin
            state     <= ARMED;
            o_PENDING <= 1'b1;
          end
        end
        ARMED: begin
          if (!req_cycle && !req_blank) begin
            state     <= IDLE;
            o_PENDING <= 1'b0;
          end else if (o_FRAME_TICK) begin
            state     <= APPLY;
            o_PENDING <= 1'b1;
          end
        end
        APPLY: begin
          // A fresh press landing here survives the clear and waits for the next frame.
          req_cycle <= btn_rise_c[BTN_CYCLE];
          req_blank <= btn_rise_c[BTN_BLANK];
          if (req_cycle) begin
            o_IMAGE_SEL <= (o_IMAGE_SEL == SEL_LAST) ? '0 : o_IMAGE_SEL + SEL_W'(1);
          end
          if (req_blank) begin
            o_BLANK <= ~o_BLANK;
          end
          state     <= IDLE;
          o_PENDING <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          o_PENDING <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_display_controller.sv
// Self-checking bench for vga_display_controller: scenario tasks plus randomized
// press/frame sequences checked against a per-frame request model.
module tb_vga_display_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned NIMG = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc_btn;
  logic       blk_btn;
  logic       vsync;
  logic [1:0] sel;
  logic       blank;
  logic       pend;
  logic       tick;

  int   errors = 0;
  int   checks = 0;
  int   exp_sel = 0;
  logic exp_blank = 1'b0;

  vga_display_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_IMAGES     (NIMG)
  ) dut (
    .i_CLK          (clk),
    .i_RESET_N      (rst_n),
    .i_CYCLE_IMAGE  (cyc_btn),
    .i_BLANK_DISPLAY(blk_btn),
    .i_VSYNC        (vsync),
    .o_IMAGE_SEL    (sel),
    .o_BLANK        (blank),
    .o_PENDING      (pend),
    .o_FRAME_TICK   (tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit which, input int hi, input int lo);
    if (which) blk_btn = 1'b1; else cyc_btn = 1'b1;
    step(hi);
    if (which) blk_btn = 1'b0; else cyc_btn = 1'b0;
    step(lo);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    exp_sel   = 0;
    exp_blank = 1'b0;
  endtask

  // One vsync low pulse; the model says which requests this frame must serve.
  task automatic frame(input bit app_cyc, input bit app_blk, input bit pend_after);
    int   old_sel;
    logic old_blank;
    bit   seen;
    bit   stray;
    old_sel   = exp_sel;
    old_blank = exp_blank;
    seen      = 1'b0;
    stray     = 1'b0;
    vsync     = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      if (tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_tick: no tick within 10 cycles of vsync low");
    end
    if (app_cyc) exp_sel = (exp_sel + 1) % NIMG;
    if (app_blk) exp_blank = ~exp_blank;
    checks++;
    if (pend !== (app_cyc | app_blk)) begin
      errors++;
      $display("FAIL pending_at_tick: got %b want %b", pend, app_cyc | app_blk);
    end
    step(1);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL tick_width: tick still %b one cycle later", tick);
    end
    checks++;
    if (sel !== 2'(old_sel) || blank !== old_blank) begin
      errors++;
      $display("FAIL early_update: sel=%0d blank=%b want sel=%0d blank=%b at tick+1",
               sel, blank, old_sel, old_blank);
    end
    step(1);
    checks++;
    if (sel !== 2'(exp_sel) || blank !== exp_blank) begin
      errors++;
      $display("FAIL apply_result: sel=%0d blank=%b want sel=%0d blank=%b at tick+2",
               sel, blank, exp_sel, exp_blank);
    end
    checks++;
    if (pend !== pend_after) begin
      errors++;
      $display("FAIL pending_after: got %b want %b", pend, pend_after);
    end
    vsync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (tick !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL stray_tick: tick seen on vsync rising/high, want none");
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst_n   = 1'b0;
    cyc_btn = 1'b0;
    blk_btn = 1'b0;
    vsync   = 1'b1;
    step(3);
    checks++;
    if (sel !== 2'd0 || blank !== 1'b0 || pend !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d blank=%b pend=%b tick=%b want all 0",
               sel, blank, pend, tick);
    end
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick !== 1'b0 || pend !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: tick or pending asserted with idle inputs, want 0");
    end
    exp_sel   = 0;
    exp_blank = 1'b0;
  endtask

  task automatic test_single_press();
    press(1'b0, 10, 8);
    checks++;
    if (pend !== 1'b1) begin
      errors++;
      $display("FAIL single_pending: got %b want 1", pend);
    end
    frame(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc_btn = ~cyc_btn;
      step(2);
      if (pend !== 1'b0) bad = 1'b1;
    end
    cyc_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pend !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bounce_pending: pending rose on a bouncing button, want 0");
    end
    frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 8, 8);
      frame(1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (sel !== 2'd0) begin
      errors++;
      $display("FAIL wrap: sel=%0d want 0 after three advances", sel);
    end
    for (int i = 0; i < 3; i++) press(1'b0, 6, 7);
    frame(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_blank();
    press(1'b1, 8, 8);
    checks++;
    if (pend !== 1'b1) begin
      errors++;
      $display("FAIL blank_armed: pend=%b want 1 after one blank press", pend);
    end
    press(1'b1, 8, 8);
    checks++;
    if (pend !== 1'b0) begin
      errors++;
      $display("FAIL blank_cancel: pend=%b want 0 after two blank presses", pend);
    end
    frame(1'b0, 1'b0, 1'b0);
    press(1'b1, 8, 8);
    frame(1'b0, 1'b1, 1'b0);
  endtask

  // A cycle press whose debounce completes in the apply cycle must not be lost.
  task automatic test_apply_race();
    int  lat;
    bit  seen;
    int  old_sel;
    press(1'b0, 8, 8);
    old_sel = exp_sel;
    cyc_btn = 1'b1;
    step(2);
    vsync = 1'b0;
    seen  = 1'b0;
    lat   = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      lat++;
      if (tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != 2) begin
      errors++;
      $display("FAIL tick_latency: seen=%b after %0d cycles, want tick 2 cycles after vsync low",
               seen, lat);
    end
    exp_sel = (old_sel + 1) % NIMG;
    step(2);
    checks++;
    if (sel !== 2'(exp_sel)) begin
      errors++;
      $display("FAIL race_first_apply: sel=%0d want %0d", sel, exp_sel);
    end
    step(1);
    checks++;
    if (pend !== 1'b1) begin
      errors++;
      $display("FAIL race_rearm: pend=%b want 1 for press landing in apply", pend);
    end
    cyc_btn = 1'b0;
    vsync   = 1'b1;
    step(10);
    frame(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit bad;
    do_reset();
    press(1'b0, 8, 8);
    checks++;
    if (pend !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_armed: pend=%b want 1", pend);
    end
    vsync = 1'b0;
    step(1);
    rst_n = 1'b0;
    step(1);
    checks++;
    if (sel !== 2'd0 || blank !== 1'b0 || pend !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: sel=%0d blank=%b pend=%b tick=%b want all 0",
               sel, blank, pend, tick);
    end
    rst_n = 1'b1;
    vsync = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (pend !== 1'b0 || sel !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset_discard: request survived reset");
    end
    exp_sel   = 0;
    exp_blank = 1'b0;
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
  endtask

  // Random press mixes per frame: any cycle press advances once, blank presses toggle by parity.
  task automatic test_random();
    int nc;
    int nb;
    int rc;
    int rb;
    bit want;
    for (int it = 0; it < 12; it++) begin
      nc = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      rc = nc;
      rb = nb;
      while (rc + rb > 0) begin
        if (rb == 0 || (rc > 0 && $urandom_range(0, 1) == 0)) begin
          press(1'b0, $urandom_range(5, 12), $urandom_range(6, 12));
          rc--;
        end else begin
          press(1'b1, $urandom_range(5, 12), $urandom_range(6, 12));
          rb--;
        end
      end
      step($urandom_range(0, 5));
      want = (nc > 0) || (nb % 2 == 1);
      checks++;
      if (pend !== want) begin
        errors++;
        $display("FAIL rand_pending it=%0d: got %b want %b (nc=%0d nb=%0d)",
                 it, pend, want, nc, nb);
      end
      frame(nc > 0, nb % 2 == 1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    cyc_btn = 1'b0;
    blk_btn = 1'b0;
    vsync   = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_blank();
    test_apply_race();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_display_controller.md
VGA_DISPLAY_CONTROLLER -- requirements
Module: vga_display_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 Parameter NUM_IMAGES, default 3, number of selectable images; legal range 2..16.
REQ-003 i_CLK  input  1  pixel clock (divided VGA clock); all logic on rising edge.
REQ-004 i_RESET_N  input  1  synchronous, active-low reset.
REQ-005 i_CYCLE_IMAGE  input  1  raw tactile button, active-high, asynchronous, bouncing.
REQ-006 i_BLANK_DISPLAY  input  1  raw tactile button, active-high, asynchronous, bouncing.
REQ-007 i_VSYNC  input  1  vertical sync from the scanline driver, active-low.
REQ-008 o_IMAGE_SEL  output  $clog2(NUM_IMAGES)  image index to the image driver.
REQ-009 o_BLANK  output  1  1 = image driver forces black.
REQ-010 o_PENDING  output  1  debug; 1 while a request waits for a frame boundary.
REQ-011 o_FRAME_TICK  output  1  one-cycle pulse per detected frame boundary.

Function
REQ-012 Each button input SHALL pass a 2-flop synchronizer; i_VSYNC SHALL pass a separate 2-flop synchronizer.
REQ-013 Per button: a debounce counter SHALL reset to 0 whenever the synchronized level equals the debounced level, else increment; at DEBOUNCE_CYCLES-1 the debounced level SHALL flip and the counter SHALL clear.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and SHALL never wrap.
REQ-015 Debounced 0->1 of cycle button SHALL set flag req_cycle; repeat presses before apply SHALL NOT accumulate (one advance per frame maximum).
REQ-016 Debounced 0->1 of blank button SHALL toggle flag req_blank; two presses before apply SHALL cancel.
REQ-017 Frame boundary = synchronized vsync 1 followed by 0 on the next cycle; o_FRAME_TICK SHALL assert for exactly that cycle.
REQ-018 FSM states: IDLE, ARMED, APPLY.
REQ-019 IDLE -> ARMED when req_cycle or req_blank is 1.
REQ-020 ARMED -> IDLE when both flags return to 0 (cancelled blank); else ARMED -> APPLY on a frame-boundary cycle.
REQ-021 APPLY (one cycle): if req_cycle, o_IMAGE_SEL SHALL increment, wrapping NUM_IMAGES-1 -> 0; if req_blank, o_BLANK SHALL invert; both flags SHALL clear; next state IDLE.
REQ-022 Latency: frame boundary in cycle N (ARMED) -> APPLY in N+1 -> new outputs visible in N+2.
REQ-023 A debounced edge in the APPLY cycle SHALL win over the clear (flag set or toggled from 0) and be served at the next frame boundary.
REQ-024 A frame boundary while in IDLE or APPLY SHALL only pulse o_FRAME_TICK.
REQ-025 o_PENDING SHALL be 1 exactly in ARMED and APPLY.
REQ-026 o_IMAGE_SEL and o_BLANK SHALL change only in the cycle after APPLY, never mid-frame.

Reset
REQ-027 While i_RESET_N=0 at a clock edge: o_IMAGE_SEL=0, o_BLANK=0, o_PENDING=0, o_FRAME_TICK=0, FSM=IDLE, flags=0, debounce counters=0, debounced levels=0.
REQ-028 Button synchronizers SHALL reset to 0; the vsync synchronizer SHALL reset to 1 so no spurious frame boundary follows reset.
REQ-029 Reset mid-operation SHALL discard pending requests; outputs SHALL return to reset values in the cycle after the reset edge.

Verification (DEBOUNCE_CYCLES=4, NUM_IMAGES=3)
REQ-030 Reset, vsync held high, buttons low -> o_IMAGE_SEL=0, o_BLANK=0, o_PENDING=0, no o_FRAME_TICK.
REQ-031 Cycle button 1 for 10 cycles, then one vsync low pulse -> o_PENDING=1 until apply; o_IMAGE_SEL 0->1 exactly 2 cycles after the o_FRAME_TICK cycle.
REQ-032 Cycle button toggling every 2 cycles for 20 cycles, then steady 0 -> no debounced edge, o_PENDING stays 0, o_IMAGE_SEL unchanged.
REQ-033 Three separate cycle presses each followed by a frame -> o_IMAGE_SEL 1,2,0 (wrap); three presses within one frame -> single advance.
REQ-034 Two blank presses before a frame -> FSM ARMED->IDLE, o_BLANK stays 0; one press + frame -> o_BLANK=1 only at frame boundary +2 cycles.
REQ-035 Press cycle, assert i_RESET_N=0 one cycle before the frame boundary, release -> o_PENDING=0, o_IMAGE_SEL=0, no change at following frames.
